mips_dbus: RTL and testbench

//  Data-side bus unit directly downstream of the single-cycle MIPS core: consumes memwrite/memaddr/

---
 rtl/mips_dbus_defs.sv | 47 ++++
 rtl/dbus_txfifo.sv | 57 +++++
 rtl/mips_dbus.sv | 120 ++++++++++++
 tb/tb_mips_dbus.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbus_defs.sv
// rtl/mips_dbus_defs.sv - shared MMIO map, STATUS layout and address decode for mips_dbus
package mips_dbus_defs;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

    localparam logic [7:0]  OFF_TXDATA = 8'h00;
    localparam logic [7:0]  OFF_STATUS = 8'h04;
    localparam logic [7:0]  OFF_CYCLE  = 8'h08;
    localparam logic [7:0]  OFF_CMP    = 8'h0C;
    localparam logic [7:0]  OFF_CTRL   = 8'h10;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_MATCH     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_CMP,
        SEL_CTRL
    } sel_e;

    // addr[1:0] never changes the target: accesses are whole words.
    function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
        sel_e s;
        s = SEL_NONE;
        if (addr < ram_bytes) begin
            s = SEL_RAM;
        end else if (addr[31:8] == MMIO_BASE[31:8]) begin
            case ({addr[7:2], 2'b00})
                OFF_TXDATA: s = SEL_TXDATA;
                OFF_STATUS: s = SEL_STATUS;
                OFF_CYCLE:  s = SEL_CYCLE;
                OFF_CMP:    s = SEL_CMP;
                OFF_CTRL:   s = SEL_CTRL;
                default:    s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dbus_txfifo.sv
// rtl/dbus_txfifo.sv - synchronous TX byte FIFO with registered storage and overflow strobe
module dbus_txfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_push
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop);
    assign ovf_push = push & full & ~do_pop;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_dbus.sv
// rtl/mips_dbus.sv - data-side bus unit: word RAM, TX FIFO, cycle counter and compare MMIO
module mips_dbus
    import mips_dbus_defs::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    sel_e          sel;
    logic [31:0]   counter;
    logic [31:0]   cmp;
    logic          irq_en;
    logic          match_flag;
    logic          ovf;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_push;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          wr_status;

    assign sel       = decode(memaddr, 32'(RAM_WORDS * 4));
    assign push      = memwrite & (sel == SEL_TXDATA);
    assign wr_status = memwrite & (sel == SEL_STATUS);
    assign tx_valid  = ~fifo_empty;
    assign irq       = match_flag & irq_en;

    dbus_txfifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txfifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (memwritedata[7:0]),
        .pop      (tx_ready),
        .dout     (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .ovf_push (ovf_push)
    );

    // Data RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (memwrite && sel == SEL_RAM) begin
            ram[memaddr[RAM_AW+1:2]] <= memwritedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter    <= '0;
            cmp        <= 32'hFFFF_FFFF;
            irq_en     <= 1'b0;
            match_flag <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (memwrite && sel == SEL_CYCLE) begin
                counter <= memwritedata;
            end else begin
                counter <= counter + 32'd1;
            end
            if (memwrite && sel == SEL_CMP) begin
                cmp <= memwritedata;
            end
            if (memwrite && sel == SEL_CTRL) begin
                irq_en <= memwritedata[0];
            end
            // Setting wins over a write-1-to-clear landing in the same cycle.
            if (counter == cmp) begin
                match_flag <= 1'b1;
            end else if (wr_status && memwritedata[ST_MATCH]) begin
                match_flag <= 1'b0;
            end
            if (ovf_push) begin
                ovf <= 1'b1;
            end else if (wr_status && memwritedata[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_COUNT_LSB +: 8]  = 8'(fifo_count);
        status[ST_OVF]             = ovf;
        status[ST_MATCH]           = match_flag;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
    end

    always_comb begin
        memreaddata = '0;
        case (sel)
            SEL_RAM:    memreaddata = ram[memaddr[RAM_AW+1:2]];
            SEL_STATUS: memreaddata = status;
            SEL_CYCLE:  memreaddata = counter;
            SEL_CMP:    memreaddata = cmp;
            SEL_CTRL:   memreaddata = {31'b0, irq_en};
            default:    memreaddata = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_dbus.sv
// tb/tb_mips_dbus.sv - self-checking bench for mips_dbus with a queue-based reference model
module tb_mips_dbus;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP = 32'hFFFF_000C;
    localparam logic [31:0] A_CTL = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = 32'h0000_2000;
    logic [31:0] memwritedata = '0;
    logic [31:0] memreaddata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        irq;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    mips_dbus dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0]  q[$];
    logic [31:0] mram [64];
    bit          mvalid [64];
    logic [31:0] mcnt = 0;
    logic [31:0] mcmp = 32'hFFFF_FFFF;
    bit          mirq_en = 0;
    bit          mmatch = 0;
    bit          movf = 0;

    function automatic logic [31:0] mread(input logic [31:0] a, output bit known);
        known = 1;
        if (a < 32'd256) begin
            known = mvalid[a[7:2]];
            return mram[a[7:2]];
        end
        if (a[31:8] != 24'hFFFF00) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h04:   return {16'b0, 8'(q.size()), 4'b0, movf, mmatch, (q.size() == 4), (q.size() == 0)};
            8'h08:   return mcnt;
            8'h0C:   return mcmp;
            8'h10:   return {31'b0, mirq_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit          mm;
        logic [7:0]  off;
        if (!reset) begin
            q.delete();
            mcnt    = 0;
            mcmp    = 32'hFFFF_FFFF;
            mirq_en = 0;
            mmatch  = 0;
            movf    = 0;
        end else begin
            mm  = (memaddr[31:8] == 24'hFFFF00);
            off = memaddr[7:0] & 8'hFC;
            if (mcnt == mcmp) mmatch = 1;
            else if (memwrite && mm && off == 8'h04 && memwritedata[2]) mmatch = 0;
            if (memwrite && mm && off == 8'h04 && memwritedata[3]) movf = 0;
            if (q.size() > 0 && tx_ready) void'(q.pop_front());
            if (memwrite && mm && off == 8'h00) begin
                if (q.size() < 4) q.push_back(memwritedata[7:0]);
                else movf = 1;
            end
            if (memwrite && mm && off == 8'h08) mcnt = memwritedata;
            else mcnt = mcnt + 1;
            if (memwrite && mm && off == 8'h0C) mcmp = memwritedata;
            if (memwrite && mm && off == 8'h10) mirq_en = memwritedata[0];
            if (memwrite && memaddr < 32'd256) begin
                mram[memaddr[7:2]]   = memwritedata;
                mvalid[memaddr[7:2]] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        bit          known;
        logic [31:0] e;
        if (started && reset) begin
            e = mread(memaddr, known);
            if (known) chk("model_rdata", memreaddata, e);
            chk("model_tx_valid", 32'(tx_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("model_tx_data", 32'(tx_data), 32'(q[0]));
            chk("model_irq", 32'(irq), 32'(mmatch & mirq_en));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite     = 1'b1;
        memaddr      = a;
        memwritedata = d;
        cyc();
        memwrite     = 1'b0;
        memaddr      = 32'h0000_2000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        memwrite = 1'b0;
        memaddr  = a;
        #1;
        chk(name, memreaddata, exp);
        memaddr  = 32'h0000_2000;
    endtask

    logic [7:0] drain2 [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] drain3 [4] = '{8'h42, 8'h43, 8'h44, 8'h55};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        repeat (2) cyc();
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(A_ST, 32'h0000_0001, "rst_status");
        rd(A_CYC, 32'h0, "rst_cycle");
        rd(A_CMP, 32'hFFFF_FFFF, "rst_cmp");
        rd(A_CTL, 32'h0, "rst_ctrl");
        reset   = 1'b1;
        started = 1;

        // 1: RAM store then load; unmapped load
        wr(32'h0000_0010, 32'h1234_5678);
        rd(32'h0000_0010, 32'h1234_5678, "ram_rdback");
        rd(32'h0000_2000, 32'h0, "unmapped_rd");
        wr(32'h0000_00FC, 32'hCAFE_F00D);
        rd(32'h0000_00FE, 32'hCAFE_F00D, "ram_top_word");

        // 2: overflow the FIFO, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h41 + i);
        rd(A_ST, 32'h0000_040A, "full_ovf_status");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain2_byte", 32'(tx_data), 32'(drain2[i]));
            cyc();
        end
        tx_ready = 1'b0;
        chk("drain2_empty", 32'(tx_valid), 32'h0);
        wr(A_ST, 32'h8);
        rd(A_ST, 32'h0000_0001, "ovf_w1c");

        // 3: push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i);
        memwrite = 1'b1; memaddr = A_TX; memwritedata = 32'h55; tx_ready = 1'b1;
        cyc();
        memwrite = 1'b0; memaddr = 32'h0000_2000; tx_ready = 1'b0;
        chk("fullpp_head", 32'(tx_data), 32'h42);
        rd(A_ST, 32'h0000_0402, "fullpp_status");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain3_byte", 32'(tx_data), 32'(drain3[i]));
            cyc();
        end
        tx_ready = 1'b0;

        // 4: compare match, irq, and W1C of match_flag
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        wr(A_CMP, 32'd20);
        wr(A_CTL, 32'd1);
        n = 0;
        while (!irq && n < 40) begin
            cyc();
            n++;
        end
        chk("irq_latency", 32'(n), 32'd19);
        rd(A_CYC, 32'd21, "cycle_at_match");
        rd(A_ST, 32'h0000_0005, "match_status");
        wr(A_ST, 32'h4);
        rd(A_ST, 32'h0000_0001, "match_w1c");
        chk("irq_cleared", 32'(irq), 32'h0);

        // 5: counter wrap
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, 32'hFFFF_FFFE, "cyc_wr");
        cyc();
        rd(A_CYC, 32'hFFFF_FFFF, "cyc_max");
        cyc();
        rd(A_CYC, 32'h0, "cyc_wrap");

        // 6: asynchronous reset mid-cycle with bytes queued
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + i);
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_tx_data", 32'(tx_data), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        rd(A_ST, 32'h0000_0001, "async_status");
        rd(A_CYC, 32'h0, "async_cycle");
        rd(A_CMP, 32'hFFFF_FFFF, "async_cmp");
        cyc();
        reset = 1'b1;

        // 7: push and pop together on an empty FIFO: push only
        memwrite = 1'b1; memaddr = A_TX; memwritedata = 32'h77; tx_ready = 1'b1;
        cyc();
        memwrite = 1'b0; memaddr = 32'h0000_2000; tx_ready = 1'b0;
        chk("emptypp_valid", 32'(tx_valid), 32'h1);
        chk("emptypp_data", 32'(tx_data), 32'h77);
        rd(A_ST, 32'h0000_0100, "emptypp_status");
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
